// File: rtl/mcu_ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_ahb_pkg
//  Description : Shared AHB bus codes, arbiter state encoding and the
//                MAU alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mcu_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Size code 3 is not a legal MAU access and is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic r;
        case (size)
            2'd0:    r = 1'b0;
            2'd1:    r = addr_lo[0];
            2'd2:    r = (addr_lo != 2'd0);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_master_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_arb_if
//  Description : IFU/MAU request channels plus the AHB master bus, bundled.
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_master_arb_if;

    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        ifu_err;

    logic        mau_req;
    logic        mau_write;
    logic [31:0] mau_addr;
    logic [1:0]  mau_size;
    logic [31:0] mau_wdata;
    logic        mau_gnt;
    logic        mau_rvalid;
    logic [31:0] mau_rdata;
    logic        mau_err;

    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [2:0]  hburst;
    logic [6:0]  hprot;
    logic        hmastlock;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        input  ifu_req, ifu_addr,
        output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        input  mau_req, mau_write, mau_addr, mau_size, mau_wdata,
        output mau_gnt, mau_rvalid, mau_rdata, mau_err,
        output haddr, hwrite, hsize, htrans, hwdata, hburst, hprot, hmastlock,
        input  hready, hresp, hrdata
    );

    modport slave (
        output ifu_req, ifu_addr,
        input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        output mau_req, mau_write, mau_addr, mau_size, mau_wdata,
        input  mau_gnt, mau_rvalid, mau_rdata, mau_err,
        input  haddr, hwrite, hsize, htrans, hwdata, hburst, hprot, hmastlock,
        output hready, hresp, hrdata
    );

endinterface
`default_nettype wire

// File: rtl/ahb_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_arb_pick
//  Description : IFU/MAU priority pick with IFU starvation counter.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_arb_en,
    input  wire logic i_ifu_req,
    input  wire logic i_mau_req,
    input  wire logic i_mau_misaligned,
    output logic      o_grant_ifu,
    output logic      o_grant_mau,
    output logic      o_reject_mau
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;
    logic             w_ifu_wins;
    logic             w_mau_wins;

    assign w_starved  = (r_starve_cnt == C_STARVE_MAX);
    assign w_ifu_wins = i_arb_en && i_ifu_req && (!i_mau_req || w_starved);
    assign w_mau_wins = i_arb_en && i_mau_req && !w_ifu_wins;

    assign o_grant_ifu  = w_ifu_wins;
    assign o_grant_mau  = w_mau_wins && !i_mau_misaligned;
    assign o_reject_mau = w_mau_wins &&  i_mau_misaligned;

    // A rejected MAU access never reaches the bus, so it does not count as an IFU loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_ifu_wins) begin
            r_starve_cnt <= '0;
        end else if (o_grant_mau && i_ifu_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_arb
//  Description : Single-outstanding AHB master shared by the IFU and the MAU.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_master_arb
    import mcu_ahb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  wire logic        hclk,
    input  wire logic        hrst,
    ahb_master_arb_if.master bus
);

    arb_state_t  r_state;
    logic        r_owner_ifu;
    logic [31:0] r_wdata;

    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [1:0]  r_htrans;
    logic [31:0] r_hwdata;

    logic        r_ifu_gnt;
    logic        r_ifu_rvalid;
    logic [31:0] r_ifu_rdata;
    logic        r_ifu_err;
    logic        r_mau_gnt;
    logic        r_mau_rvalid;
    logic [31:0] r_mau_rdata;
    logic        r_mau_err;

    logic        w_arb_en;
    logic        w_mau_misaligned;
    logic        w_grant_ifu;
    logic        w_grant_mau;
    logic        w_reject_mau;

    assign w_arb_en         = (r_state == ST_IDLE);
    assign w_mau_misaligned = is_misaligned(bus.mau_size, bus.mau_addr[1:0]);

    ahb_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk              (hclk),
        .rst              (hrst),
        .i_arb_en         (w_arb_en),
        .i_ifu_req        (bus.ifu_req),
        .i_mau_req        (bus.mau_req),
        .i_mau_misaligned (w_mau_misaligned),
        .o_grant_ifu      (w_grant_ifu),
        .o_grant_mau      (w_grant_mau),
        .o_reject_mau     (w_reject_mau)
    );

    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_state      <= ST_IDLE;
            r_owner_ifu  <= 1'b0;
            r_wdata      <= '0;
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
            r_hsize      <= '0;
            r_htrans     <= HTRANS_IDLE;
            r_hwdata     <= '0;
            r_ifu_gnt    <= 1'b0;
            r_ifu_rvalid <= 1'b0;
            r_ifu_rdata  <= '0;
            r_ifu_err    <= 1'b0;
            r_mau_gnt    <= 1'b0;
            r_mau_rvalid <= 1'b0;
            r_mau_rdata  <= '0;
            r_mau_err    <= 1'b0;
        end else begin
            r_ifu_gnt    <= 1'b0;
            r_ifu_rvalid <= 1'b0;
            r_ifu_err    <= 1'b0;
            r_mau_gnt    <= 1'b0;
            r_mau_rvalid <= 1'b0;
            r_mau_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_ifu) begin
                        r_state     <= ST_ADDR;
                        r_owner_ifu <= 1'b1;
                        r_ifu_gnt   <= 1'b1;
                        r_haddr     <= bus.ifu_addr;
                        r_hwrite    <= 1'b0;
                        r_hsize     <= HSIZE_WORD;
                        r_wdata     <= '0;
                        r_htrans    <= HTRANS_NONSEQ;
                    end else if (w_grant_mau) begin
                        r_state     <= ST_ADDR;
                        r_owner_ifu <= 1'b0;
                        r_mau_gnt   <= 1'b1;
                        r_haddr     <= bus.mau_addr;
                        r_hwrite    <= bus.mau_write;
                        r_hsize     <= {1'b0, bus.mau_size};
                        r_wdata     <= bus.mau_write ? bus.mau_wdata : 32'd0;
                        r_htrans    <= HTRANS_NONSEQ;
                    end else if (w_reject_mau) begin
                        // Misaligned access: answer with an error, no bus cycle.
                        r_mau_rvalid <= 1'b1;
                        r_mau_err    <= 1'b1;
                    end
                end

                ST_ADDR: begin
                    if (bus.hready) begin
                        r_state  <= ST_DATA;
                        r_htrans <= HTRANS_IDLE;
                        r_hwdata <= r_wdata;
                    end
                end

                ST_DATA: begin
                    if (bus.hready) begin
                        r_state  <= ST_IDLE;
                        r_hwdata <= '0;
                        if (r_owner_ifu) begin
                            r_ifu_rvalid <= 1'b1;
                            r_ifu_rdata  <= bus.hrdata;
                            r_ifu_err    <= bus.hresp;
                        end else begin
                            r_mau_rvalid <= 1'b1;
                            r_mau_rdata  <= bus.hrdata;
                            r_mau_err    <= bus.hresp;
                        end
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_htrans <= HTRANS_IDLE;
                end
            endcase
        end
    end

    assign bus.ifu_gnt    = r_ifu_gnt;
    assign bus.ifu_rvalid = r_ifu_rvalid;
    assign bus.ifu_rdata  = r_ifu_rdata;
    assign bus.ifu_err    = r_ifu_err;
    assign bus.mau_gnt    = r_mau_gnt;
    assign bus.mau_rvalid = r_mau_rvalid;
    assign bus.mau_rdata  = r_mau_rdata;
    assign bus.mau_err    = r_mau_err;

    assign bus.haddr     = r_haddr;
    assign bus.hwrite    = r_hwrite;
    assign bus.hsize     = r_hsize;
    assign bus.htrans    = r_htrans;
    assign bus.hwdata    = r_hwdata;
    assign bus.hburst    = 3'd0;
    assign bus.hprot     = 7'd0;
    assign bus.hmastlock = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_master_arb
//  Description : Directed and randomized self-checking bench for ahb_master_arb.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_master_arb;

    localparam int STARVE = 4;

    logic clk;
    logic rst;

    ahb_master_arb_if bus ();

    ahb_master_arb #(
        .STARVE_MAX (STARVE)
    ) dut (
        .hclk (clk),
        .hrst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_ifu;
        logic [31:0] addr;
        bit          write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } txn_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the transfer in flight and where it is in its life.
    txn_t        m_txn;
    int          m_phase;   // 0 no transfer, 1 address phase, 2 data phase
    int          m_starve;
    bit          e_rst;
    bit          e_ifu_gnt, e_mau_gnt, e_ifu_rvalid, e_mau_rvalid, e_ifu_err, e_mau_err;
    logic [31:0] e_ifu_rdata, e_mau_rdata;

    bit mau_outstanding;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        return (addr % (32'd1 << size)) != 32'd0;
    endfunction

    task automatic model_step();
        bit ifu_wins, mau_wins;
        e_ifu_gnt = 0; e_mau_gnt = 0; e_ifu_rvalid = 0; e_mau_rvalid = 0;
        e_ifu_err = 0; e_mau_err = 0; e_rst = 0;
        if (rst) begin
            m_phase = 0; m_starve = 0; e_ifu_rdata = 0; e_mau_rdata = 0; e_rst = 1;
        end else if (m_phase == 0) begin
            ifu_wins = bus.ifu_req && (!bus.mau_req || m_starve >= STARVE);
            mau_wins = bus.mau_req && !ifu_wins;
            if (ifu_wins) begin
                m_txn.is_ifu = 1; m_txn.addr = bus.ifu_addr; m_txn.write = 0;
                m_txn.size = 3'd2; m_txn.wdata = 0;
                m_phase = 1; e_ifu_gnt = 1; m_starve = 0;
            end else if (mau_wins) begin
                if (m_misaligned(bus.mau_size, bus.mau_addr)) begin
                    e_mau_rvalid = 1; e_mau_err = 1;
                end else begin
                    m_txn.is_ifu = 0; m_txn.addr = bus.mau_addr; m_txn.write = bus.mau_write;
                    m_txn.size = {1'b0, bus.mau_size}; m_txn.wdata = bus.mau_wdata;
                    m_phase = 1; e_mau_gnt = 1;
                    if (bus.ifu_req && m_starve < STARVE) m_starve++;
                end
            end
        end else if (m_phase == 1) begin
            if (bus.hready) m_phase = 2;
        end else if (bus.hready) begin
            if (m_txn.is_ifu) begin
                e_ifu_rvalid = 1; e_ifu_rdata = bus.hrdata; e_ifu_err = bus.hresp;
            end else begin
                e_mau_rvalid = 1; e_mau_rdata = bus.hrdata; e_mau_err = bus.hresp;
            end
            m_phase = 0;
        end
    endtask

    task automatic compare();
        chk("ifu_gnt",    bus.ifu_gnt,    e_ifu_gnt);
        chk("mau_gnt",    bus.mau_gnt,    e_mau_gnt);
        chk("ifu_rvalid", bus.ifu_rvalid, e_ifu_rvalid);
        chk("mau_rvalid", bus.mau_rvalid, e_mau_rvalid);
        chk("ifu_err",    bus.ifu_err,    e_ifu_err);
        chk("mau_err",    bus.mau_err,    e_mau_err);
        chk("ifu_rdata",  bus.ifu_rdata,  e_ifu_rdata);
        chk("mau_rdata",  bus.mau_rdata,  e_mau_rdata);
        chk("htrans",     bus.htrans,     (m_phase == 1) ? 32'd2 : 32'd0);
        chk("hconst",     {bus.hburst, bus.hprot, bus.hmastlock}, 32'd0);
        if (e_rst) begin
            chk("rst_haddr",  bus.haddr,  0);
            chk("rst_hwrite", bus.hwrite, 0);
            chk("rst_hsize",  bus.hsize,  0);
            chk("rst_hwdata", bus.hwdata, 0);
        end else if (m_phase == 1) begin
            chk("haddr",  bus.haddr,  m_txn.addr);
            chk("hwrite", bus.hwrite, m_txn.write);
            chk("hsize",  bus.hsize,  m_txn.size);
        end else if (m_phase == 2) begin
            chk("hwdata", bus.hwdata, m_txn.write ? m_txn.wdata : 32'd0);
        end
    endtask

    // Requesters drop their request once the grant (or a reject) is seen.
    task automatic requester_ack();
        if (bus.ifu_gnt) bus.ifu_req = 0;
        if (bus.mau_gnt) begin
            bus.mau_req = 0; mau_outstanding = 1;
        end else if (bus.mau_rvalid) begin
            if (mau_outstanding) mau_outstanding = 0;
            else bus.mau_req = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
        requester_ack();
    endtask

    task automatic do_reset();
        rst = 1; bus.ifu_req = 0; bus.mau_req = 0; mau_outstanding = 0;
        tick();
        rst = 0;
    endtask

    task automatic mau_set(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
        bus.mau_req = 1; bus.mau_write = wr; bus.mau_addr = a;
        bus.mau_size = sz; bus.mau_wdata = wd;
    endtask

    task automatic rand_drive();
        bus.hready = ($urandom_range(0, 3) != 0);
        bus.hresp  = ($urandom_range(0, 7) == 0);
        bus.hrdata = $urandom;
        if ($urandom_range(0, 199) == 0) begin
            rst = 1; bus.ifu_req = 0; bus.mau_req = 0; mau_outstanding = 0;
        end else begin
            rst = 0;
            if (!bus.ifu_req && $urandom_range(0, 2) == 0) begin
                bus.ifu_req = 1; bus.ifu_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!bus.mau_req && $urandom_range(0, 2) == 0) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
                mau_set($urandom_range(0, 1) == 1, a,
                        ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                        $urandom);
            end
        end
    endtask

    initial begin
        int mau_wins;
        bit got;
        rst = 1;
        bus.ifu_req = 0; bus.ifu_addr = 0;
        bus.mau_req = 0; bus.mau_write = 0; bus.mau_addr = 0; bus.mau_size = 0; bus.mau_wdata = 0;
        bus.hready = 1; bus.hresp = 0; bus.hrdata = 0;
        mau_outstanding = 0; m_phase = 0; m_starve = 0;
        e_ifu_rdata = 0; e_mau_rdata = 0;

        // Reset state and single IFU fetch.
        do_reset();
        chk("lit_rst_htrans", bus.htrans, 0);
        chk("lit_rst_gnt", {bus.ifu_gnt, bus.mau_gnt, bus.ifu_rvalid, bus.mau_rvalid}, 0);
        bus.hready = 1; bus.hresp = 0; bus.hrdata = 32'h0000_0013;
        bus.ifu_req = 1; bus.ifu_addr = 32'h0000_0100;
        tick();
        chk("lit_fetch_gnt",    bus.ifu_gnt, 1);
        chk("lit_fetch_htrans", bus.htrans,  2);
        chk("lit_fetch_haddr",  bus.haddr,   32'h100);
        tick();
        chk("lit_fetch_data_htrans", bus.htrans, 0);
        tick();
        chk("lit_fetch_rvalid", bus.ifu_rvalid, 1);
        chk("lit_fetch_rdata",  bus.ifu_rdata,  32'h13);
        tick();
        chk("lit_fetch_rvalid_clr", bus.ifu_rvalid, 0);

        // Simultaneous requests: MAU first, IFU on the next grant slot.
        do_reset();
        bus.hready = 1; bus.hrdata = 32'h1111_2222;
        bus.ifu_req = 1; bus.ifu_addr = 32'h200;
        mau_set(0, 32'h2000_0004, 2'd2, 0);
        tick();
        chk("lit_both_mau_gnt", bus.mau_gnt, 1);
        chk("lit_both_ifu_nogn", bus.ifu_gnt, 0);
        tick(); tick();
        chk("lit_both_mau_rvalid", bus.mau_rvalid, 1);
        tick();
        chk("lit_both_ifu_gnt", bus.ifu_gnt, 1);
        repeat (3) tick();

        // Starvation: MAU keeps re-requesting while IFU waits.
        do_reset();
        bus.hready = 1;
        bus.ifu_req = 1; bus.ifu_addr = 32'h300;
        mau_wins = 0; got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            if (!bus.mau_req) mau_set(0, 32'h2000_0004, 2'd2, 0);
            tick();
            if (bus.mau_gnt) mau_wins++;
            if (bus.ifu_gnt) got = 1;
        end
        chk("lit_starve_ifu_granted", got, 1);
        chk("lit_starve_wins_le_max", (mau_wins <= STARVE), 1);
        repeat (10) tick();

        // Store with two wait states in the address phase.
        do_reset();
        bus.hready = 0; bus.hresp = 0;
        mau_set(1, 32'h2000_0008, 2'd2, 32'hDEAD_BEEF);
        tick();
        chk("lit_st_gnt", bus.mau_gnt, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lit_st_haddr_hold",  bus.haddr,  32'h2000_0008);
            chk("lit_st_hwrite_hold", bus.hwrite, 1);
            chk("lit_st_htrans_hold", bus.htrans, 2);
        end
        bus.hready = 1;
        tick();
        chk("lit_st_hwdata", bus.hwdata, 32'hDEAD_BEEF);
        tick();
        chk("lit_st_rvalid", bus.mau_rvalid, 1);
        chk("lit_st_err",    bus.mau_err,    0);

        // Misaligned halfword load is rejected without a bus cycle.
        do_reset();
        bus.hready = 1;
        mau_set(0, 32'h2000_0003, 2'd1, 0);
        tick();
        chk("lit_mis_rvalid", bus.mau_rvalid, 1);
        chk("lit_mis_err",    bus.mau_err,    1);
        chk("lit_mis_nogn",   bus.mau_gnt,    0);
        chk("lit_mis_htrans", bus.htrans,     0);
        tick();
        chk("lit_mis_rvalid_clr", bus.mau_rvalid, 0);
        chk("lit_mis_htrans2",    bus.htrans,     0);

        // Load completing with an error response.
        do_reset();
        bus.hready = 1; bus.hresp = 1; bus.hrdata = 32'hCAFE_0001;
        mau_set(0, 32'h2000_0004, 2'd2, 0);
        repeat (3) tick();
        chk("lit_herr_rvalid", bus.mau_rvalid, 1);
        chk("lit_herr_err",    bus.mau_err,    1);
        chk("lit_herr_rdata",  bus.mau_rdata,  32'hCAFE_0001);
        bus.hresp = 0;

        // Reset during the data phase abandons the fetch.
        do_reset();
        bus.hready = 1; bus.hrdata = 32'h5555_AAAA;
        bus.ifu_req = 1; bus.ifu_addr = 32'h300;
        tick(); tick();
        rst = 1;
        tick();
        chk("lit_rstd_rvalid", bus.ifu_rvalid, 0);
        chk("lit_rstd_haddr",  bus.haddr,      0);
        chk("lit_rstd_rdata",  bus.ifu_rdata,  0);
        rst = 0;
        tick();
        chk("lit_rstd_norvalid", bus.ifu_rvalid, 0);
        bus.ifu_req = 1; bus.ifu_addr = 32'h400;
        tick();
        chk("lit_rstd_regnt",  bus.ifu_gnt, 1);
        chk("lit_rstd_haddr2", bus.haddr,   32'h400);
        repeat (3) tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rand_drive();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_master_arb.md
AHB_MASTER_ARB -- requirements
Module: ahb_master_arb

Interface
REQ-001 The block SHALL expose parameter STARVE_MAX, default 4, meaning the number of consecutive IFU arbitration losses before IFU is forced to win.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL provide these ports (name  direction  width  meaning):
  hclk  in  1  bus/core clock, rising edge
  hrst  in  1  synchronous active-high reset
  ifu_req  in  1  IFU fetch request, held until ifu_gnt
  ifu_addr  in  32  IFU fetch address, word access
  ifu_gnt  out  1  one-cycle grant pulse to IFU
  ifu_rvalid  out  1  one-cycle fetch completion pulse
  ifu_rdata  out  32  fetched word, valid with ifu_rvalid
  ifu_err  out  1  error flag, valid with ifu_rvalid
  mau_req  in  1  MAU load/store request, held until mau_gnt or mau_rvalid
  mau_write  in  1  1 = store, 0 = load
  mau_addr  in  32  MAU byte address
  mau_size  in  2  0 byte, 1 halfword, 2 word
  mau_wdata  in  32  store data
  mau_gnt  out  1  one-cycle grant pulse to MAU
  mau_rvalid  out  1  one-cycle completion pulse, loads and stores
  mau_rdata  out  32  raw load word, valid with mau_rvalid
  mau_err  out  1  error flag, valid with mau_rvalid
  haddr  out  32  AHB address
  hwrite  out  1  AHB write
  hsize  out  3  AHB size
  htrans  out  2  AHB transfer type
  hwdata  out  32  AHB write data
  hburst  out  3  AHB burst, constant 0
  hprot  out  7  AHB protection, constant 0
  hmastlock  out  1  AHB lock, constant 0
  hready  in  1  AHB ready
  hresp  in  1  AHB error response
  hrdata  in  32  AHB read data

Function
REQ-004 The block SHALL implement states IDLE, ADDR, DATA; one transfer outstanding at a time, no pipelining.
REQ-005 In IDLE with any request pending, state SHALL go to ADDR on the next edge; with none pending, it SHALL stay in IDLE.
REQ-006 In IDLE, MAU SHALL win when both request, unless starve_cnt == STARVE_MAX, in which case IFU SHALL win.
REQ-007 starve_cnt SHALL increment, saturating at STARVE_MAX, each time IFU requests and loses; it SHALL clear to 0 when IFU is granted.
REQ-008 On entry to ADDR, the grant pulse for the winner SHALL be high for exactly that first ADDR cycle.
REQ-009 On that same edge, haddr, hwrite, hsize and the write data SHALL be registered from the winner's inputs.
REQ-010 IFU transfers SHALL use hsize=2, hwrite=0.
REQ-011 In ADDR, htrans SHALL be NONSEQ; hready=1 SHALL move to DATA and hready=0 SHALL hold ADDR with all address-phase outputs stable.
REQ-012 In DATA, htrans SHALL be IDLE and hwdata SHALL carry the captured store data (0 for reads).
REQ-013 In DATA, hready=1 SHALL move to IDLE, and the owner's rvalid SHALL pulse the following cycle with rdata=hrdata and err=hresp, both sampled at completion.
REQ-014 Minimum latency, with hready=1 throughout: request in cycle 0, gnt and NONSEQ in cycle 1, DATA in cycle 2, rvalid in cycle 3; a new grant can occur no earlier than cycle 4.
REQ-015 A misaligned MAU request SHALL be rejected without a bus transfer: no gnt, mau_rvalid and mau_err pulse the cycle after arbitration, state stays IDLE, and starve_cnt is unaffected.
  Misaligned means: halfword with addr[0]=1; word with addr[1:0]!=0; mau_size=3.
REQ-016 Outside their defined cycles, rvalid, gnt and err SHALL be 0; rdata SHALL hold its last value.
REQ-017 hburst, hprot and hmastlock SHALL be 0 at all times.

Reset
REQ-018 While hrst=1, state SHALL be IDLE, starve_cnt 0, and haddr, hwdata, hwrite, htrans, hsize, every gnt/rvalid/err and every rdata 0.
REQ-019 Reset asserted mid-transfer SHALL abandon the transfer with no rvalid.
REQ-020 The first request SHALL be accepted in the first IDLE cycle after hrst falls.

Structure
REQ-021 The following SHALL live in the shared bus package mcu_ahb_pkg: HTRANS codes (IDLE 0, BUSY 1, NONSEQ 2, SEQ 3), HSIZE codes, and the arbiter state encoding.
REQ-022 The priority pick and starve_cnt logic SHALL be one sub-module, ahb_arb_pick; everything else SHALL stay in ahb_master_arb.

Verification
REQ-023 IFU-only fetch of 0x0000_0100, hready=1, hrdata=0x0000_0013:
  ifu_gnt in cycle 1, htrans=NONSEQ and haddr=0x100 in cycle 1, ifu_rvalid and ifu_rdata=0x13 in cycle 3.
REQ-024 Simultaneous ifu_req and mau_req (load, 0x2000_0004, word) held continuously:
  MAU granted first, IFU second.
  With MAU re-requesting repeatedly, IFU is granted after at most 4 MAU wins.
REQ-025 MAU store 0xDEADBEEF to 0x2000_0008 with hready=0 for 2 cycles in ADDR:
  haddr and hwrite=1 held stable, hwdata=0xDEADBEEF in DATA, mau_rvalid=1 and mau_err=0 at completion.
REQ-026 MAU halfword load at 0x2000_0003:
  no NONSEQ issued, mau_rvalid=1 and mau_err=1 one cycle later.
REQ-027 Load completing with hresp=1:
  mau_err=1 with mau_rvalid.
REQ-028 hrst=1 during DATA:
  all outputs 0 the next cycle, no rvalid, and a fresh IFU request is granted normally after release.
